// File: rtl/dac_seq_ctrl_if.sv
// AXI-Stream pair between the waveform FIFO, the playback controller and the DAC tile.
// slave: controller side (consumes s_axis, produces m_axis). master: environment side.
interface dac_seq_ctrl_if #(
  parameter int DATA_W = 256
);
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid
  );
endinterface

// File: rtl/dac_seq_ctrl.sv
// DAC playback controller: triggered playback of FIFO beats with pre/post delay,
// repeat count, first/last-beat lane masks, sticky underrun and abort.
// Config registers are shadowed at trigger so mid-run writes hit the next run only.
module dac_seq_ctrl #(
  parameter int LANES    = 16,
  parameter int SAMPLE_W = 16,
  parameter int CNT_W    = 32
)(
  input  logic                      clk,
  input  logic                      rst,
  dac_seq_ctrl_if.slave             axis,
  input  logic                      cfg_we,
  input  logic [2:0]                cfg_addr,
  input  logic [CNT_W-1:0]          cfg_wdata,
  input  logic [LANES*SAMPLE_W-1:0] idle_data,
  input  logic                      trigger_in,
  input  logic                      abort_in,
  output logic                      mux_sel,
  output logic                      loopback_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      underrun
);
  localparam int DATA_W = LANES*SAMPLE_W;

  typedef enum logic [1:0] {IDLE, PRE, RUN, POST} state_t;
  state_t state;

  // live config registers
  logic [CNT_W-1:0] r_cycle, r_pre, r_post, r_rep;
  logic [LANES-1:0] r_fmask, r_lmask;
  logic [2:0]       r_ctrl;

  // run-time shadows and counters; cnt times whichever of PRE/RUN/POST is active
  logic [CNT_W-1:0] s_cycle, s_pre, s_post, rep_left, cnt;
  logic [LANES-1:0] s_fmask, s_lmask;
  logic             s_mask_en;

  logic              run_act, beat, is_first, is_last, trig_ok, seg_end;
  logic [DATA_W-1:0] masked, tdata_q;
  logic              unused_tready;

  assign run_act  = (state == RUN) && !abort_in;
  assign beat     = run_act && axis.s_axis_tvalid;
  assign is_first = (cnt == s_cycle);
  assign is_last  = (cnt == CNT_W'(1));
  assign trig_ok  = (state == IDLE) && trigger_in && !abort_in && (r_cycle != '0);
  // end of a repeat: last POST cycle, or last beat when there is no POST
  assign seg_end  = ((state == POST) && is_last) ||
                    (beat && is_last && (s_post == '0));

  assign axis.s_axis_tready = run_act;
  assign axis.m_axis_tvalid = 1'b1;
  assign axis.m_axis_tdata  = tdata_q;
  assign loopback_valid     = beat;
  assign busy               = (state != IDLE);
  assign mux_sel            = r_ctrl[1];
  assign unused_tready      = axis.m_axis_tready;

  // per-lane edge masking; cycle_count==1 makes the beat both first and last
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic keep;
    assign keep = !s_mask_en || ((!is_first || s_fmask[i]) && (!is_last || s_lmask[i]));
    assign masked[i*SAMPLE_W +: SAMPLE_W] = keep ? axis.s_axis_tdata[i*SAMPLE_W +: SAMPLE_W]
                                                 : '0;
  end

  // config register writes, accepted in any state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle <= '0; r_pre <= '0; r_post <= '0; r_rep <= '0;
      r_fmask <= '0; r_lmask <= '0; r_ctrl <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        3'd0:    r_cycle <= cfg_wdata;
        3'd1:    r_pre   <= cfg_wdata;
        3'd2:    r_post  <= cfg_wdata;
        3'd3:    r_rep   <= cfg_wdata;
        3'd4:    r_fmask <= cfg_wdata[LANES-1:0];
        3'd5:    r_lmask <= cfg_wdata[LANES-1:0];
        3'd6:    r_ctrl  <= cfg_wdata[2:0];
        default: ;
      endcase
    end
  end

  // playback sequencer: trigger/abort first, then repeat decision, then per-state counting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rep_left <= '0;
      s_cycle  <= '0; s_pre <= '0; s_post <= '0;
      s_fmask  <= '0; s_lmask <= '0; s_mask_en <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      done <= 1'b0;
      if (trig_ok) begin
        s_cycle   <= r_cycle;
        s_pre     <= r_pre;
        s_post    <= r_post;
        s_fmask   <= r_fmask;
        s_lmask   <= r_lmask;
        s_mask_en <= r_ctrl[0];
        rep_left  <= r_rep;
        underrun  <= 1'b0;
        if (r_pre != '0) begin
          state <= PRE;
          cnt   <= r_pre;
        end else begin
          state <= RUN;
          cnt   <= r_cycle;
        end
      end else if ((state != IDLE) && abort_in) begin
        state <= IDLE;
      end else if (seg_end) begin
        if (rep_left != '0) begin
          rep_left <= rep_left - 1'b1;
          if (s_pre != '0) begin
            state <= PRE;
            cnt   <= s_pre;
          end else begin
            state <= RUN;
            cnt   <= s_cycle;
          end
        end else begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end else begin
        case (state)
          PRE: begin
            if (is_last) begin
              state <= RUN;
              cnt   <= s_cycle;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          RUN: begin
            if (!axis.s_axis_tvalid) begin
              underrun <= 1'b1;
            end else if (is_last) begin
              state <= POST;
              cnt   <= s_post;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          POST:    cnt <= cnt - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // output register: consumed beat, idle waveform, or zeros
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             tdata_q <= '0;
    else if (beat)                        tdata_q <= masked;
    else if ((state == IDLE) && r_ctrl[2]) tdata_q <= idle_data;
    else                                  tdata_q <= '0;
  end
endmodule

// File: tb/tb_dac_seq_ctrl.sv
// Directed bench for dac_seq_ctrl: table of playback scenarios plus hand sequences
// for underrun, abort, mid-run config writes and reset.
module tb_dac_seq_ctrl;
  localparam int LANES    = 16;
  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = 32;
  localparam int DATA_W   = LANES*SAMPLE_W;
  localparam int MAXC     = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cfg_we = 1'b0;
  logic [2:0]        cfg_addr = '0;
  logic [CNT_W-1:0]  cfg_wdata = '0;
  logic [DATA_W-1:0] idle_data = '0;
  logic              trigger_in = 1'b0, abort_in = 1'b0;
  logic              mux_sel, loopback_valid, busy, done, underrun;

  int errors = 0;
  int checks = 0;

  dac_seq_ctrl_if #(.DATA_W(DATA_W)) bus();

  dac_seq_ctrl #(.LANES(LANES), .SAMPLE_W(SAMPLE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .axis(bus),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .idle_data(idle_data), .trigger_in(trigger_in), .abort_in(abort_in),
    .mux_sel(mux_sel), .loopback_valid(loopback_valid), .busy(busy),
    .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // per-cycle capture of one playback
  logic              busy_a[MAXC], rdy_a[MAXC], cons_a[MAXC], lb_a[MAXC], done_a[MAXC], ur_a[MAXC];
  logic [DATA_W-1:0] out_a[MAXC], in_a[MAXC];

  typedef struct {
    int              cyc, pre, post, rep;
    logic [2:0]      ctrl;
    logic [LANES-1:0] fm, lm;
    int              exp_busy, exp_beats, exp_done_cyc;
    logic [63:0]     exp_rdy;
    logic [LANES-1:0] exp_first, exp_second, exp_last;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] expand(input logic [LANES-1:0] m);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) if (m[i]) r[i*SAMPLE_W +: SAMPLE_W] = '1;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] pat(input int c);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(c*LANES + i + 'h31);
    return r;
  endfunction

  task automatic cfg_write(input logic [2:0] a, input logic [CNT_W-1:0] d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic configure(input vec_t v);
    cfg_write(3'd0, v.cyc);
    cfg_write(3'd1, v.pre);
    cfg_write(3'd2, v.post);
    cfg_write(3'd3, v.rep);
    cfg_write(3'd4, CNT_W'(v.fm));
    cfg_write(3'd5, CNT_W'(v.lm));
    cfg_write(3'd6, CNT_W'(v.ctrl));
  endtask

  // drive n cycles after posedge, capture at negedge; trigger only in cycle 0
  task automatic play(input int n, input bit trig = 1'b1, input int st_from = -1,
                      input int st_len = 0, input int ab_at = -1, input bit ones = 1'b1,
                      input int cf_at = -1, input logic [2:0] cf_a = '0,
                      input logic [CNT_W-1:0] cf_d = '0);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      trigger_in        = trig && (c == 0);
      abort_in          = (c == ab_at);
      bus.s_axis_tvalid = !((c >= st_from) && (c < st_from + st_len));
      in_a[c]           = ones ? {DATA_W{1'b1}} : pat(c);
      bus.s_axis_tdata  = in_a[c];
      cfg_we            = (c == cf_at);
      cfg_addr          = cf_a;
      cfg_wdata         = cf_d;
      @(negedge clk);
      busy_a[c] = busy;
      rdy_a[c]  = bus.s_axis_tready;
      cons_a[c] = bus.s_axis_tready && bus.s_axis_tvalid;
      lb_a[c]   = loopback_valid;
      done_a[c] = done;
      ur_a[c]   = underrun;
      out_a[c]  = bus.m_axis_tdata;
    end
    @(posedge clk); #1;
    trigger_in = 1'b0; abort_in = 1'b0; cfg_we = 1'b0; bus.s_axis_tvalid = 1'b1;
  endtask

  function automatic int count_of(input int n, input int which);
    int s;
    s = 0;
    for (int c = 0; c < n; c++) begin
      case (which)
        0: s += int'(busy_a[c]);
        1: s += int'(cons_a[c]);
        2: s += int'(done_a[c]);
        default: s += int'(lb_a[c]);
      endcase
    end
    return s;
  endfunction

  initial begin
    tbl[0] = '{4, 2, 3, 0, 3'b000, 16'h0000, 16'h0000, 9, 4, 10, 64'h78,
               16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[1] = '{3, 0, 0, 0, 3'b001, 16'h00FF, 16'hFF00, 3, 3, 4, 64'hE,
               16'h00FF, 16'hFFFF, 16'hFF00};
    tbl[2] = '{1, 0, 0, 0, 3'b001, 16'h00FF, 16'hFF00, 1, 1, 2, 64'h2,
               16'h0000, 16'h0000, 16'h0000};
    tbl[3] = '{2, 1, 1, 2, 3'b000, 16'h0000, 16'h0000, 12, 6, 13, 64'hCCC,
               16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[4] = '{2, 0, 0, 1, 3'b001, 16'h0F0F, 16'hF0F0, 4, 4, 5, 64'h1E,
               16'h0F0F, 16'hF0F0, 16'hF0F0};
    tbl[5] = '{0, 0, 0, 0, 3'b000, 16'h0000, 16'h0000, 0, 0, -1, 64'h0,
               16'h0000, 16'h0000, 16'h0000};

    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b1;
    bus.m_axis_tready = 1'b1;
    idle_data         = pat(20);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", DATA_W'(busy), '0);
    chk("rst_done", DATA_W'(done), '0);
    chk("rst_underrun", DATA_W'(underrun), '0);
    chk("rst_mux_sel", DATA_W'(mux_sel), '0);
    chk("rst_loopback", DATA_W'(loopback_valid), '0);
    chk("rst_tready", DATA_W'(bus.s_axis_tready), '0);
    chk("rst_tvalid", DATA_W'(bus.m_axis_tvalid), DATA_W'(1));
    chk("rst_tdata", bus.m_axis_tdata, '0);
    @(posedge clk); #1;
    rst = 1'b1;

    // table-driven playback scenarios
    for (int k = 0; k < 6; k++) begin
      logic [63:0] rmap;
      int fc, sc, lc;
      configure(tbl[k]);
      play(20);
      rmap = '0; fc = -1; sc = -1; lc = -1;
      for (int c = 0; c < 20; c++) begin
        if (rdy_a[c]) rmap[c] = 1'b1;
        if (cons_a[c]) begin
          if (fc < 0) fc = c;
          else if (sc < 0) sc = c;
          lc = c;
        end
      end
      chk($sformatf("v%0d_busy_cycles", k), DATA_W'(count_of(20, 0)), DATA_W'(tbl[k].exp_busy));
      chk($sformatf("v%0d_beats", k), DATA_W'(count_of(20, 1)), DATA_W'(tbl[k].exp_beats));
      chk($sformatf("v%0d_loopback", k), DATA_W'(count_of(20, 3)), DATA_W'(tbl[k].exp_beats));
      chk($sformatf("v%0d_tready_map", k), DATA_W'(rmap), DATA_W'(tbl[k].exp_rdy));
      chk($sformatf("v%0d_done_count", k), DATA_W'(count_of(20, 2)),
          DATA_W'(tbl[k].exp_done_cyc < 0 ? 0 : 1));
      if (tbl[k].exp_done_cyc >= 0)
        chk($sformatf("v%0d_done_cycle", k), DATA_W'(done_a[tbl[k].exp_done_cyc]), DATA_W'(1));
      if (tbl[k].exp_beats > 0 && fc >= 0 && lc + 1 < MAXC) begin
        chk($sformatf("v%0d_first_beat", k), out_a[fc+1], expand(tbl[k].exp_first));
        chk($sformatf("v%0d_last_beat", k), out_a[lc+1], expand(tbl[k].exp_last));
      end
      if (tbl[k].exp_beats >= 3 && sc >= 0)
        chk($sformatf("v%0d_second_beat", k), out_a[sc+1], expand(tbl[k].exp_second));
    end

    // underrun: 3-cycle stall mid-run extends the run, outputs zeros, stays sticky
    configure('{4, 0, 0, 0, 3'b000, 16'h0, 16'h0, 0, 0, 0, 64'h0, 16'h0, 16'h0, 16'h0});
    play(12, 1'b1, 2, 3, -1, 1'b0);
    chk("ur_beats", DATA_W'(count_of(12, 1)), DATA_W'(4));
    chk("ur_busy_cycles", DATA_W'(count_of(12, 0)), DATA_W'(7));
    chk("ur_done_cycle", DATA_W'(done_a[8]), DATA_W'(1));
    chk("ur_before_stall", DATA_W'(ur_a[2]), '0);
    chk("ur_sticky", DATA_W'(ur_a[11]), DATA_W'(1));
    chk("ur_out_beat0", out_a[2], in_a[1]);
    chk("ur_out_stall0", out_a[3], '0);
    chk("ur_out_stall1", out_a[4], '0);
    chk("ur_out_stall2", out_a[5], '0);
    chk("ur_out_beat1", out_a[6], in_a[5]);
    chk("ur_out_beat3", out_a[8], in_a[7]);
    play(12);
    chk("ur_held_until_trigger", DATA_W'(ur_a[0]), DATA_W'(1));
    chk("ur_cleared_by_trigger", DATA_W'(ur_a[1]), '0);

    // abort in RUN after 2 of 8 beats, idle waveform enabled
    configure('{8, 0, 0, 0, 3'b100, 16'h0, 16'h0, 0, 0, 0, 64'h0, 16'h0, 16'h0, 16'h0});
    play(12, 1'b1, -1, 0, 3, 1'b0);
    chk("ab_beats", DATA_W'(count_of(12, 1)), DATA_W'(2));
    chk("ab_tready_same_cycle", DATA_W'(rdy_a[3]), '0);
    chk("ab_busy_during", DATA_W'(busy_a[3]), DATA_W'(1));
    chk("ab_idle_next", DATA_W'(busy_a[4]), '0);
    chk("ab_no_done", DATA_W'(count_of(12, 2)), '0);
    chk("ab_out_zero", out_a[4], '0);
    chk("ab_out_idle_data", out_a[5], idle_data);
    // abort together with trigger in IDLE: trigger dropped
    play(6, 1'b1, -1, 0, 0);
    chk("ab_trig_ignored", DATA_W'(count_of(6, 0)), '0);

    // mid-run write of cycle_count only affects the next run
    configure('{3, 0, 0, 0, 3'b000, 16'h0, 16'h0, 0, 0, 0, 64'h0, 16'h0, 16'h0, 16'h0});
    play(12, 1'b1, -1, 0, -1, 1'b1, 2, 3'd0, 9);
    chk("mw_old_len", DATA_W'(count_of(12, 1)), DATA_W'(3));
    play(16);
    chk("mw_new_len", DATA_W'(count_of(16, 1)), DATA_W'(9));
    chk("mw_new_busy", DATA_W'(count_of(16, 0)), DATA_W'(9));

    // mux_sel follows ctrl bit1 immediately
    cfg_write(3'd6, 2);
    @(negedge clk);
    chk("mux_sel_set", DATA_W'(mux_sel), DATA_W'(1));

    // asynchronous reset mid-run
    cfg_write(3'd0, 8);
    cfg_write(3'd6, 0);
    @(posedge clk); #1;
    trigger_in = 1'b1; bus.s_axis_tvalid = 1'b1; bus.s_axis_tdata = pat(3);
    @(posedge clk); #1;
    trigger_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mr_busy_before", DATA_W'(busy), DATA_W'(1));
    chk("mr_tdata_before", bus.m_axis_tdata, pat(3));
    rst = 1'b0;
    #1;
    chk("mr_busy_after", DATA_W'(busy), '0);
    chk("mr_tdata_after", bus.m_axis_tdata, '0);
    chk("mr_mux_sel_after", DATA_W'(mux_sel), '0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    trigger_in = 1'b1;
    @(posedge clk); #1;
    trigger_in = 1'b0;
    @(negedge clk);
    chk("mr_regs_cleared", DATA_W'(busy), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
